down_counter_cascade: RTL and testbench
=======================================

// Module: down_counter_cascade
// PURPOSE
//  Fully synchronous presettable binary DOWN counter built from cascaded 4-bit slices.
//  Counterpart of the 4-bit up counter used for PC/timing chains:
//  - counts toward zero;
//  - signals borrow instead of carry.
//  Used for loop/delay counters and programmable dividers in the CPU datapath.
// PARAMETERS
//  SLICES   2   number of 4-bit slices; counter width W = 4*SLICES
// PORTS
//  clk      in   1   rising-edge clock
//  rst      in   1   asynchronous, active-high reset
//  load_n   in   1   synchronous parallel load, active low
//  enp      in   1   count enable (parallel)
//  ent      in   1   count enable (trickle); also gates borrow chain
//  P        in   W   parallel preset value
//  Q        out  W   current count
//  bo       out  1   registered borrow-out flag, for cascading to further counters
// BEHAVIOUR
//  Reset:
//  - rst=1 forces Q=0 and bo=0 immediately, independent of clk.
//  - rst deassertion is sampled by the next clk edge; no count occurs on that edge if rst is still high.
//  Priority at each posedge (rst=0): load_n=0 > (enp&ent)=1 decrement > hold.
//  Load:
//  - Q <= P; bo <= 0.
//  - enp/ent are ignored.
//  Decrement:
//  - Q <= Q-1 modulo 2^W.
//  - bo <= 1 iff the pre-edge Q==1, i.e. bo is high for exactly the cycle in which Q==0 after counting down.
//  - Any other decrement clears bo.
//  Hold: Q and bo keep their values (bo stays high while a reached zero is held).
//  Wrap-around (macro absent): decrement from 0 gives all-ones (8'hFF for W=8); bo <= 0.
//  Latency: Q and bo change only on clk edges (one-cycle, registered); no combinational path from inputs to outputs.
//  Slice cascade:
//  - slice i decrements iff enp&ent and slices 0..i-1 are all zero (borrow lookahead, same edge);
//  - the result must equal plain W-bit subtraction.
//  Loading P=0 then holding: Q=0, bo=0 (bo marks counted-to-zero only, never loaded-zero).
//  ent=0, enp=1 (or the reverse): hold, no partial slice update.
// CONFIGURATION
//  DOWN_COUNTER_AUTORELOAD_EN defined:
//  - a decrement with pre-edge Q==0 loads Q <= P instead of wrapping; bo <= 0;
//  - the block becomes a divide-by-(P+1) counter; P=0 gives Q stuck at 0 and bo pulsing only after the first 1->0.
//  DOWN_COUNTER_AUTORELOAD_EN undefined: plain modulo-2^W wrap as above.
//  All other behaviour is identical in both builds.
// STRUCTURE
//  Shared header counter_defs.vh:
//  - SLICE_W = 4;
//  - the priority encoding constants (LOAD/COUNT/HOLD) used by all 74xx-style counters.
//  Sub-module down_slice_4 (instantiated SLICES times via generate):
//  - inputs: clk, rst, load, en, borrow_in, P[3:0];
//  - outputs: Q[3:0], zero;
//  - borrow_in of slice i = AND of zero from slices below it.
//  Top level holds the bo register and the optional autoreload mux.
// TESTING
//  1 Reset: rst=1 mid-count with Q=8'h5A -> Q=0, bo=0 before next clk edge; held through clocks while rst=1.
//  2 Load/count: load_n=0, P=8'h03; then 3 edges with enp=ent=1:
//    Q=03->02->01->00, bo=1 only in the 00 cycle; next edge Q=FF, bo=0.
//  3 Cross-slice borrow: load 8'h10, one decrement -> Q=8'h0F; load 8'h00, decrement -> Q=8'hFF
//    (macro off).
//  4 Enables/priority:
//    - ent=0,enp=1 and ent=1,enp=0 for 4 edges -> Q unchanged;
//    - load_n=0 with enp=ent=1, P=8'h22 -> Q=22, bo=0.
//  5 Hold at zero: reach Q=0 with bo=1, drop enp for 3 edges -> bo stays 1; load P=0 -> bo=0.
//  6 Autoreload build: P=8'h02, free-run 9 edges -> Q sequence 02,01,00,02,01,00,...;
//    bo high on each 00; compare against behavioural W-bit reference.

Source files
------------

// File: rtl/down_counter_cascade_pkg.sv
// Shared definitions for the cascaded 74xx-style counters: slice width and
// the load/count/hold priority encoding.
package down_counter_cascade_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_COUNT = 2'd1,
    OP_LOAD  = 2'd2
  } cnt_op_e;

  // Load beats counting; counting needs both parallel and trickle enables.
  function automatic cnt_op_e decode_op(input logic load_n, input logic enp, input logic ent);
    cnt_op_e op;
    if (!load_n) begin
      op = OP_LOAD;
    end else if (enp && ent) begin
      op = OP_COUNT;
    end else begin
      op = OP_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/down_slice_4.sv
// One 4-bit presettable down-counter slice; decrements only when enabled and
// every lower slice is at zero (borrow lookahead).
module down_slice_4
  import down_counter_cascade_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               en,
  input  logic               borrow_in,
  input  logic [SLICE_W-1:0] P,
  output logic [SLICE_W-1:0] Q,
  output logic               zero
);

  // Slice count register: load has priority over a borrowed decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q <= 4'h0;
    end else if (load) begin
      Q <= P;
    end else if (en && borrow_in) begin
      Q <= Q - 4'h1;
    end else begin
      Q <= Q;
    end
  end

  assign zero = (Q == 4'h0);

endmodule

// File: rtl/down_counter_cascade.sv
// Presettable W-bit down counter built from SLICES cascaded 4-bit slices.
// Define DOWN_COUNTER_AUTORELOAD_EN to reload P on a decrement from zero.
module down_counter_cascade
  import down_counter_cascade_pkg::*;
#(
  parameter int SLICES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_n,
  input  logic                  enp,
  input  logic                  ent,
  input  logic [SLICES*4-1:0]   P,
  output logic [SLICES*4-1:0]   Q,
  output logic                  bo
);

  localparam int W = SLICES * SLICE_W;

  cnt_op_e           op_s;
  logic [SLICES:0]   borrow_s;
  logic [SLICES-1:0] zero_s;
  logic              all_zero_s;
  logic              reload_s;
  logic              slice_load_s;
  logic              slice_en_s;
  logic              q_is_one_s;

  assign op_s        = decode_op(load_n, enp, ent);
  assign borrow_s[0] = 1'b1;
  assign all_zero_s  = borrow_s[SLICES];
  assign q_is_one_s  = (Q == W'(1));

`ifdef DOWN_COUNTER_AUTORELOAD_EN
  assign reload_s = (op_s == OP_COUNT) && all_zero_s;
`else
  assign reload_s = 1'b0;
`endif

  assign slice_load_s = (op_s == OP_LOAD) || reload_s;
  assign slice_en_s   = (op_s == OP_COUNT) && !reload_s;

  for (genvar i = 0; i < SLICES; i++) begin : g_slice
    down_slice_4 u_slice (
      .clk       (clk),
      .rst       (rst),
      .load      (slice_load_s),
      .en        (slice_en_s),
      .borrow_in (borrow_s[i]),
      .P         (P[i*SLICE_W +: SLICE_W]),
      .Q         (Q[i*SLICE_W +: SLICE_W]),
      .zero      (zero_s[i])
    );
    assign borrow_s[i+1] = borrow_s[i] && zero_s[i];
  end

  // Borrow-out flag: set only by counting 1 -> 0, never by loading zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bo <= 1'b0;
    end else begin
      case (op_s)
        OP_LOAD:  bo <= 1'b0;
        OP_COUNT: bo <= q_is_one_s;
        OP_HOLD:  bo <= bo;
        default:  bo <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_down_counter_cascade.sv
// Directed bench for down_counter_cascade (SLICES=2, W=8).
// Build with DOWN_COUNTER_AUTORELOAD_EN to exercise the autoreload variant.
module tb_down_counter_cascade;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_n;
  logic       enp;
  logic       ent;
  logic [7:0] P;
  logic [7:0] Q;
  logic       bo;

  int vectors = 0;
  int miscompares = 0;

  down_counter_cascade #(.SLICES(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .load_n (load_n),
    .enp    (enp),
    .ent    (ent),
    .P      (P),
    .Q      (Q),
    .bo     (bo)
  );

  always #5 clk = ~clk;

  // Apply inputs, take one rising edge, settle 1 time unit past it.
  task automatic step(input logic l_n, input logic ep, input logic et, input logic [7:0] pv);
    load_n = l_n;
    enp    = ep;
    ent    = et;
    P      = pv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; load_n = 1'b1; enp = 1'b0; ent = 1'b0; P = 8'h00;
    #3;
    vectors++;
    if (Q !== 8'h00 || bo !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_init Q=%h bo=%b expected Q=00 bo=0", Q, bo);
    end
    #9 rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 8'h5A);
    vectors++;
    if (Q !== 8'h5A) begin
      miscompares++;
      $display("FAIL reset_preload Q=%h expected 5a", Q);
    end
    enp = 1'b1; ent = 1'b1; load_n = 1'b1;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (Q !== 8'h00 || bo !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async Q=%h bo=%b expected Q=00 bo=0", Q, bo);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1, 8'h00);
      vectors++;
      if (Q !== 8'h00 || bo !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_held Q=%h bo=%b expected Q=00 bo=0", Q, bo);
      end
    end
    enp = 1'b0; ent = 1'b0;
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, 8'h00);
    vectors++;
    if (Q !== 8'h00 || bo !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release Q=%h bo=%b expected Q=00 bo=0", Q, bo);
    end
  endtask

  task automatic test_load_count;
    logic [7:0] exp_q  [4] = '{8'h02, 8'h01, 8'h00, 8'hFF};
    logic       exp_bo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    step(1'b0, 1'b0, 1'b0, 8'h03);
    vectors++;
    if (Q !== 8'h03 || bo !== 1'b0) begin
      miscompares++;
      $display("FAIL load_03 Q=%h bo=%b expected Q=03 bo=0", Q, bo);
    end
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    exp_q[3] = 8'h03;
`endif
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b1, 8'h03);
      vectors++;
      if (Q !== exp_q[i] || bo !== exp_bo[i]) begin
        miscompares++;
        $display("FAIL count_%0d Q=%h bo=%b expected Q=%h bo=%b", i, Q, bo, exp_q[i], exp_bo[i]);
      end
    end
  endtask

  task automatic test_cross_slice;
    step(1'b0, 1'b0, 1'b0, 8'h10);
    step(1'b1, 1'b1, 1'b1, 8'h10);
    vectors++;
    if (Q !== 8'h0F || bo !== 1'b0) begin
      miscompares++;
      $display("FAIL borrow_10 Q=%h bo=%b expected Q=0f bo=0", Q, bo);
    end
    step(1'b0, 1'b0, 1'b0, 8'h11);
    step(1'b1, 1'b1, 1'b1, 8'h11);
    vectors++;
    if (Q !== 8'h10 || bo !== 1'b0) begin
      miscompares++;
      $display("FAIL upper_nonzero Q=%h bo=%b expected Q=10 bo=0", Q, bo);
    end
`ifndef DOWN_COUNTER_AUTORELOAD_EN
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h00);
    vectors++;
    if (Q !== 8'hFF || bo !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_00 Q=%h bo=%b expected Q=ff bo=0", Q, bo);
    end
`endif
  endtask

  task automatic test_enables;
    step(1'b0, 1'b0, 1'b0, 8'h37);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i < 4) ? 1'b1 : 1'b0, (i < 4) ? 1'b0 : 1'b1, 8'h99);
      vectors++;
      if (Q !== 8'h37) begin
        miscompares++;
        $display("FAIL enable_hold_%0d Q=%h expected 37", i, Q);
      end
    end
    step(1'b0, 1'b1, 1'b1, 8'h22);
    vectors++;
    if (Q !== 8'h22 || bo !== 1'b0) begin
      miscompares++;
      $display("FAIL load_priority Q=%h bo=%b expected Q=22 bo=0", Q, bo);
    end
  endtask

  task automatic test_hold_zero;
    step(1'b0, 1'b0, 1'b0, 8'h01);
    step(1'b1, 1'b1, 1'b1, 8'h01);
    vectors++;
    if (Q !== 8'h00 || bo !== 1'b1) begin
      miscompares++;
      $display("FAIL reach_zero Q=%h bo=%b expected Q=00 bo=1", Q, bo);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h01);
      vectors++;
      if (Q !== 8'h00 || bo !== 1'b1) begin
        miscompares++;
        $display("FAIL hold_zero_%0d Q=%h bo=%b expected Q=00 bo=1", i, Q, bo);
      end
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    vectors++;
    if (Q !== 8'h00 || bo !== 1'b0) begin
      miscompares++;
      $display("FAIL loaded_zero Q=%h bo=%b expected Q=00 bo=0", Q, bo);
    end
  endtask

  // Free run from a preset through zero, checked against a W-bit reference.
  task automatic test_back_to_back(input logic [7:0] preset, input int edges);
    logic [7:0] exp_q;
    logic [7:0] pre_q;
    logic       exp_bo;
    step(1'b0, 1'b0, 1'b0, preset);
    exp_q = preset;
    for (int i = 0; i < edges; i++) begin
      step(1'b1, 1'b1, 1'b1, preset);
      pre_q  = exp_q;
      exp_bo = (pre_q == 8'h01);
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      exp_q  = (pre_q == 8'h00) ? preset : pre_q - 8'h01;
`else
      exp_q  = pre_q - 8'h01;
`endif
      vectors++;
      if (Q !== exp_q || bo !== exp_bo) begin
        miscompares++;
        $display("FAIL run_%h_%0d Q=%h bo=%b expected Q=%h bo=%b", preset, i, Q, bo, exp_q, exp_bo);
      end
    end
  endtask

`ifdef DOWN_COUNTER_AUTORELOAD_EN
  task automatic test_autoreload;
    logic [7:0] exp_q [9] = '{8'h01, 8'h00, 8'h02, 8'h01, 8'h00, 8'h02, 8'h01, 8'h00, 8'h02};
    logic       exp_bo;
    step(1'b0, 1'b0, 1'b0, 8'h02);
    vectors++;
    if (Q !== 8'h02) begin
      miscompares++;
      $display("FAIL autoreload_load Q=%h expected 02", Q);
    end
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 1'b1, 8'h02);
      exp_bo = (exp_q[i] == 8'h00);
      vectors++;
      if (Q !== exp_q[i] || bo !== exp_bo) begin
        miscompares++;
        $display("FAIL autoreload_%0d Q=%h bo=%b expected Q=%h bo=%b", i, Q, bo, exp_q[i], exp_bo);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_count();
    test_cross_slice();
    test_enables();
    test_hold_zero();
    test_back_to_back(8'hC3, 6);
    test_back_to_back(8'h12, 22);
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    test_autoreload();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
